perceptron_trainer: RTL



---
 rtl/perceptron_pkg.sv | 28 ++
 rtl/perceptron_trainer_if.sv | 26 ++
 rtl/perceptron_dot.sv | 25 ++
 rtl/perceptron_trainer.sv | 113 +++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron branch predictor: weight table,
// lookup path and trainer all use these definitions.
package perceptron_pkg;

  localparam int N     = 62;   // weights per perceptron, index 0 is the bias
  localparam int WIDTH = 8;
  localparam int INDEX = 6;
  localparam int SUM_W = 16;
  localparam int THETA = 131;  // floor(1.93*(N-1)+14)

  typedef logic signed [WIDTH-1:0] weight_t;
  typedef weight_t     [N-1:0]     row_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic        [N-2:0]     hist_t;
  typedef logic        [INDEX-1:0] idx_t;

  typedef enum logic [1:0] {IDLE, READ, EVAL, WRITE} trainer_state_t;

  localparam weight_t W_MAX = weight_t'((2 ** (WIDTH - 1)) - 1);
  localparam weight_t W_MIN = weight_t'(-(2 ** (WIDTH - 1)));

  // Move a weight one step toward the target sign, sticking at the rails.
  function automatic weight_t sat_step(weight_t w, logic inc);
    if (inc) return (w == W_MAX) ? w : w + weight_t'(1);
    return (w == W_MIN) ? w : w - weight_t'(1);
  endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Trainer bus: resolved-branch handshake plus the weight table read/update ports.
interface perceptron_trainer_if;
  import perceptron_pkg::*;

  logic  res_valid;
  logic  res_ready;
  idx_t  res_idx;
  hist_t res_hist;
  logic  res_taken;
  idx_t  rd_idx;
  row_t  rd_weights;
  logic  wr_en;
  idx_t  wr_idx;
  row_t  wr_weights;

  modport master (
    output res_valid, res_idx, res_hist, res_taken, rd_weights,
    input  res_ready, rd_idx, wr_en, wr_idx, wr_weights
  );

  modport slave (
    input  res_valid, res_idx, res_hist, res_taken, rd_weights,
    output res_ready, rd_idx, wr_en, wr_idx, wr_weights
  );

endinterface

// File: rtl/perceptron_dot.sv
// Combinational perceptron output y = sum(w_j * x_j) with x_j = +/-1, shared by
// the lookup path and the trainer.
module perceptron_dot
  import perceptron_pkg::*;
(
  input  row_t  row_i,
  input  hist_t hist_i,
  input  logic  bias_i,
  output sum_t  y_o
);

  sum_t acc;

  // NOTE: blocking assignments here are intentional; each loop iteration must
  // see the accumulator value left by the previous one.
  always_comb begin
    acc = bias_i ? sum_t'(row_i[0]) : -sum_t'(row_i[0]);
    for (int j = 1; j < N; j++) begin
      acc = hist_i[j-1] ? acc + sum_t'(row_i[j]) : acc - sum_t'(row_i[j]);
    end
  end

  assign y_o = acc;

endmodule

// File: rtl/perceptron_trainer.sv
// Write-side training engine: reads a row, recomputes y, and writes back a
// saturated +/-1 adjusted row when the prediction was wrong or not confident.
module perceptron_trainer
  import perceptron_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  perceptron_trainer_if.slave  bus,
  output logic [31:0]          train_cnt,
  output logic [31:0]          skip_cnt
);

  trainer_state_t state_q, state_d;

  idx_t        idx_q;
  hist_t       hist_q;
  logic        taken_q;
  row_t        row_q;
  idx_t        wr_idx_q;
  row_t        wr_weights_q;
  logic [31:0] train_cnt_q;
  logic [31:0] skip_cnt_q;

  sum_t y;
  sum_t abs_y;
  logic predicted;
  logic train;
  row_t new_row;

  perceptron_dot u_dot (
    .row_i  (row_q),
    .hist_i (hist_q),
    .bias_i (1'b1),
    .y_o    (y)
  );

  // Train on a mispredict or whenever |y| sits inside the confidence margin.
  always_comb begin
    predicted = ~y[SUM_W-1];
    abs_y     = y[SUM_W-1] ? -y : y;
    train     = (predicted != taken_q) || (abs_y <= sum_t'(THETA));
    new_row[0] = sat_step(row_q[0], taken_q);
    for (int j = 1; j < N; j++) begin
      new_row[j] = sat_step(row_q[j], taken_q == hist_q[j-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.res_valid) state_d = READ;
      READ:    state_d = EVAL;
      EVAL:    state_d = train ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.res_ready = (state_q == IDLE);
    bus.wr_en     = (state_q == WRITE);
  end

  // NOTE: row_q is a single capture register rather than a memory array, so it
  // is reset along with the rest of the captured event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      hist_q       <= '0;
      taken_q      <= 1'b0;
      row_q        <= '0;
      wr_idx_q     <= '0;
      wr_weights_q <= '0;
      train_cnt_q  <= '0;
      skip_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.res_valid) begin
            idx_q   <= bus.res_idx;
            hist_q  <= bus.res_hist;
            taken_q <= bus.res_taken;
          end
        end
        READ: row_q <= bus.rd_weights;
        EVAL: begin
          if (train) begin
            wr_idx_q     <= idx_q;
            wr_weights_q <= new_row;
          end else begin
            skip_cnt_q <= skip_cnt_q + 32'd1;
          end
        end
        WRITE:   train_cnt_q <= train_cnt_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.rd_idx     = idx_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.wr_weights = wr_weights_q;
  assign train_cnt      = train_cnt_q;
  assign skip_cnt       = skip_cnt_q;

endmodule
